// File: rtl/inst_fetch_axi_pkg.sv
// Shared AXI encodings and exception-word layout for the instruction fetch path.
package inst_fetch_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'h00;

  localparam int EXC_FETCH_ADDR_BIT = 4;
  localparam int EXC_FETCH_BUS_BIT  = 5;

  typedef logic [31:0] exc_word_t;

  // Only the two fetch-related bits may ever be set.
  function automatic exc_word_t fetch_exc_word(input logic addr_err, input logic bus_err);
    exc_word_t w;
    w                     = 32'h0000_0000;
    w[EXC_FETCH_ADDR_BIT] = addr_err;
    w[EXC_FETCH_BUS_BIT]  = bus_err;
    return w;
  endfunction

endpackage

// File: rtl/inst_fetch_axi.sv
// Instruction-fetch AXI read master: one single-beat read outstanding at a time,
// result handed to IF/ID as a one-cycle valid pulse.
module inst_fetch_axi
  import inst_fetch_axi_pkg::*;
#(
  parameter logic [3:0]  AXI_ID   = 4'b0000,
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  output logic        pc_advance_o,
  input  logic        next_pc_valid,
  input  logic        flush,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [31:0] pc_excepttype_o
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ADDR  = 2'b01;
  localparam logic [1:0] S_DATA  = 2'b10;
  localparam logic [1:0] S_DRAIN = 2'b11;

  logic [1:0]  state_r;
  logic        flush_pending_r;
  logic [31:0] req_pc_r;
  logic        arvalid_r;
  logic        rready_r;
  logic        valid_r;
  logic        pc_advance_r;
  logic [31:0] if_pc_r;
  logic [31:0] if_inst_r;
  exc_word_t   exc_r;

  logic grant_s;
  logic r_beat_s;
  logic r_ok_s;

  // A beat with a foreign ID is never treated as our response.
  assign grant_s  = next_pc_valid & ~flush;
  assign r_beat_s = rvalid & rlast & (rid == AXI_ID);
  assign r_ok_s   = (rresp == AXI_RESP_OKAY);

  // Fetch FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= S_IDLE;
      flush_pending_r <= 1'b0;
      req_pc_r        <= 32'h0000_0000;
      arvalid_r       <= 1'b0;
      rready_r        <= 1'b0;
      valid_r         <= 1'b0;
      pc_advance_r    <= 1'b0;
      if_pc_r         <= 32'h0000_0000;
      if_inst_r       <= 32'h0000_0000;
      exc_r           <= 32'h0000_0000;
    end else begin
      pc_advance_r <= 1'b0;
      valid_r      <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (grant_s) begin
            req_pc_r     <= pc_i;
            pc_advance_r <= 1'b1;
            if (pc_i[1:0] != 2'b00) begin
              valid_r   <= 1'b1;
              if_pc_r   <= pc_i;
              if_inst_r <= 32'h0000_0000;
              exc_r     <= fetch_exc_word(1'b1, 1'b0);
            end else begin
              arvalid_r <= 1'b1;
              state_r   <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          // arvalid must not drop once raised, so a flush here is only remembered.
          if (arready) begin
            arvalid_r       <= 1'b0;
            rready_r        <= 1'b1;
            flush_pending_r <= 1'b0;
            state_r         <= (flush || flush_pending_r) ? S_DRAIN : S_DATA;
          end else if (flush) begin
            flush_pending_r <= 1'b1;
          end
        end
        S_DATA: begin
          if (flush) begin
            if (r_beat_s) begin
              rready_r <= 1'b0;
              state_r  <= S_IDLE;
            end else begin
              state_r  <= S_DRAIN;
            end
          end else if (r_beat_s) begin
            rready_r  <= 1'b0;
            valid_r   <= 1'b1;
            if_pc_r   <= req_pc_r;
            if_inst_r <= r_ok_s ? rdata : 32'h0000_0000;
            exc_r     <= fetch_exc_word(1'b0, ~r_ok_s);
            state_r   <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (r_beat_s) begin
            rready_r <= 1'b0;
            state_r  <= S_IDLE;
          end
        end
        default: begin
          state_r         <= S_IDLE;
          flush_pending_r <= 1'b0;
          arvalid_r       <= 1'b0;
          rready_r        <= 1'b0;
        end
      endcase
    end
  end

  assign arid            = AXI_ID;
  assign araddr          = req_pc_r;
  assign arlen           = AXI_LEN_SINGLE;
  assign arsize          = AXI_SIZE_4B;
  assign arburst         = AXI_BURST_INCR;
  assign arvalid         = arvalid_r;
  assign rready          = rready_r;
  assign valid           = valid_r;
  assign pc_advance_o    = pc_advance_r;
  assign if_pc           = if_pc_r;
  assign if_inst         = if_inst_r;
  assign pc_excepttype_o = exc_r;

endmodule

// File: tb/tb_inst_fetch_axi.sv
// Self-checking bench for inst_fetch_axi: vector table, random fetches against a
// spec-level model, and hand-written flush/reset sequences.
module tb_inst_fetch_axi;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        pc_advance_o;
  logic        next_pc_valid;
  logic        flush;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [31:0] pc_excepttype_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_fetch_axi dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .pc_advance_o(pc_advance_o),
    .next_pc_valid(next_pc_valid), .flush(flush),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .valid(valid), .if_pc(if_pc), .if_inst(if_inst), .pc_excepttype_o(pc_excepttype_o)
  );

  typedef struct {
    logic [31:0] pc;
    int          ar_wait;
    int          r_wait;
    logic [1:0]  resp;
    logic [31:0] data;
    logic [31:0] exp_inst;
    logic [31:0] exp_exc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference: what IF/ID must receive for one fetch.
  function automatic void model(input logic [31:0] pc, input logic [1:0] resp, input logic [31:0] data,
                                output logic [31:0] inst, output logic [31:0] exc);
    if (pc % 32'd4 != 32'd0) begin
      inst = 32'h0;
      exc  = 32'h0000_0010;
    end else if (resp != 2'b00) begin
      inst = 32'h0;
      exc  = 32'h0000_0020;
    end else begin
      inst = data;
      exc  = 32'h0;
    end
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_arvalid"}, {31'b0, arvalid}, 32'h0);
    chk({tag, "_rready"}, {31'b0, rready}, 32'h0);
    chk({tag, "_valid"}, {31'b0, valid}, 32'h0);
    chk({tag, "_pc_adv"}, {31'b0, pc_advance_o}, 32'h0);
    chk({tag, "_if_pc"}, if_pc, 32'h0);
    chk({tag, "_if_inst"}, if_inst, 32'h0);
    chk({tag, "_exc"}, pc_excepttype_o, 32'h0);
    chk({tag, "_araddr"}, araddr, 32'h0);
  endtask

  // One complete fetch; grant is issued in the current cycle, returns in the valid cycle.
  task automatic run_fetch(input logic [31:0] pc, input int ar_wait, input int r_wait,
                           input logic [1:0] resp, input logic [31:0] data,
                           input logic [31:0] exp_inst, input logic [31:0] exp_exc);
    next_pc_valid = 1'b1;
    pc_i          = pc;
    tick();
    next_pc_valid = 1'b0;
    pc_i          = 32'h1111_1110;
    chk("pc_advance", {31'b0, pc_advance_o}, 32'd1);
    if (pc[1:0] != 2'b00) begin
      chk("misalign_no_ar", {31'b0, arvalid}, 32'd0);
    end else begin
      chk("arvalid", {31'b0, arvalid}, 32'd1);
      chk("araddr", araddr, pc);
      chk("no_early_valid", {31'b0, valid}, 32'd0);
      for (int i = 0; i < ar_wait; i++) begin
        tick();
        chk("ar_hold", {31'b0, arvalid}, 32'd1);
        chk("araddr_stable", araddr, pc);
        chk("pc_adv_once", {31'b0, pc_advance_o}, 32'd0);
      end
      arready = 1'b1;
      tick();
      arready = 1'b0;
      chk("rready", {31'b0, rready}, 32'd1);
      chk("ar_dropped", {31'b0, arvalid}, 32'd0);
      chk("data_no_valid", {31'b0, valid}, 32'd0);
      for (int i = 0; i < r_wait; i++) begin
        tick();
        chk("r_wait_rready", {31'b0, rready}, 32'd1);
        chk("r_wait_no_valid", {31'b0, valid}, 32'd0);
      end
      rvalid = 1'b1; rlast = 1'b1; rid = 4'h0; rresp = resp; rdata = data;
      tick();
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = 32'h5a5a_5a5a;
      chk("rready_done", {31'b0, rready}, 32'd0);
    end
    chk("valid", {31'b0, valid}, 32'd1);
    chk("if_pc", if_pc, pc);
    chk("if_inst", if_inst, exp_inst);
    chk("excepttype", pc_excepttype_o, exp_exc);
  endtask

  vec_t vecs[5];

  initial begin
    logic [31:0] rpc, rdat, e_inst, e_exc;
    logic [1:0]  rrsp;

    rst = 1'b1; pc_i = 32'h0; next_pc_valid = 1'b0; flush = 1'b0;
    arready = 1'b0; rid = 4'h0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;

    vecs[0] = '{32'hbfc0_0000, 0, 0, 2'b00, 32'h2408_0001, 32'h2408_0001, 32'h0000_0000};
    vecs[1] = '{32'hbfc0_0004, 3, 2, 2'b00, 32'h3c1d_8000, 32'h3c1d_8000, 32'h0000_0000};
    vecs[2] = '{32'hbfc0_0002, 0, 0, 2'b00, 32'h0000_0000, 32'h0000_0000, 32'h0000_0010};
    vecs[3] = '{32'hbfc0_0008, 1, 0, 2'b10, 32'hdead_beef, 32'h0000_0000, 32'h0000_0020};
    vecs[4] = '{32'hbfc0_000c, 0, 1, 2'b11, 32'h1234_5678, 32'h0000_0000, 32'h0000_0020};

    tick(); tick();
    check_all_zero("reset");
    chk("arlen", {24'b0, arlen}, 32'h0);
    chk("arsize", {29'b0, arsize}, 32'h2);
    chk("arburst", {30'b0, arburst}, 32'h1);
    chk("arid", {28'b0, arid}, 32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++)
      run_fetch(vecs[i].pc, vecs[i].ar_wait, vecs[i].r_wait, vecs[i].resp, vecs[i].data,
                vecs[i].exp_inst, vecs[i].exp_exc);

    for (int i = 0; i < 40; i++) begin
      rpc  = $urandom;
      if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
      rrsp = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
      rdat = $urandom;
      model(rpc, rrsp, rdat, e_inst, e_exc);
      run_fetch(rpc, $urandom_range(3), $urandom_range(3), rrsp, rdat, e_inst, e_exc);
    end

    // Flush while the address is stalled: address phase completes, data drained.
    next_pc_valid = 1'b1; pc_i = 32'h8000_0100;
    tick();
    next_pc_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ar_hold", {31'b0, arvalid}, 32'd1);
    chk("flush_araddr", araddr, 32'h8000_0100);
    chk("flush_clears_valid", {31'b0, valid}, 32'd0);
    tick();
    chk("flush_ar_hold2", {31'b0, arvalid}, 32'd1);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("drain_rready", {31'b0, rready}, 32'd1);
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'hcafe_f00d;
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    chk("drain_no_valid", {31'b0, valid}, 32'd0);
    chk("drain_rready_off", {31'b0, rready}, 32'd0);
    tick();
    chk("drain_no_valid2", {31'b0, valid}, 32'd0);
    run_fetch(32'h8000_0200, 0, 0, 2'b00, 32'h0000_0042, 32'h0000_0042, 32'h0);

    // Flush and grant together: flush wins.
    next_pc_valid = 1'b1; flush = 1'b1; pc_i = 32'h8000_0300;
    tick();
    next_pc_valid = 1'b0; flush = 1'b0;
    chk("flushgrant_pc_adv", {31'b0, pc_advance_o}, 32'd0);
    chk("flushgrant_no_ar", {31'b0, arvalid}, 32'd0);
    chk("flushgrant_no_valid", {31'b0, valid}, 32'd0);
    tick();
    chk("flushgrant_no_ar2", {31'b0, arvalid}, 32'd0);

    // Grant outside IDLE is ignored; a beat with a foreign ID is not consumed.
    next_pc_valid = 1'b1; pc_i = 32'h8000_0400;
    tick();
    next_pc_valid = 1'b0;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    next_pc_valid = 1'b1; pc_i = 32'h8000_0500;
    rvalid = 1'b1; rlast = 1'b1; rid = 4'h5; rdata = 32'hbad0_bad0;
    tick();
    next_pc_valid = 1'b0;
    chk("busy_grant_no_adv", {31'b0, pc_advance_o}, 32'd0);
    chk("foreign_id_no_valid", {31'b0, valid}, 32'd0);
    chk("foreign_id_rready", {31'b0, rready}, 32'd1);
    rid = 4'h0; rdata = 32'h0bad_c0de;
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    chk("id_match_valid", {31'b0, valid}, 32'd1);
    chk("id_match_pc", if_pc, 32'h8000_0400);
    chk("id_match_inst", if_inst, 32'h0bad_c0de);

    // Flush coinciding with the R handshake: back to IDLE, no valid.
    next_pc_valid = 1'b1; pc_i = 32'h8000_0600;
    tick();
    next_pc_valid = 1'b0;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    flush = 1'b1; rvalid = 1'b1; rlast = 1'b1; rdata = 32'h7777_7777;
    tick();
    flush = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    chk("flush_hs_no_valid", {31'b0, valid}, 32'd0);
    chk("flush_hs_rready", {31'b0, rready}, 32'd0);
    chk("flush_hs_if_pc_kept", if_pc, 32'h8000_0400);
    run_fetch(32'h8000_0700, 1, 1, 2'b00, 32'h0000_0700, 32'h0000_0700, 32'h0);

    // Reset in the data phase returns everything to zero; then a normal fetch.
    next_pc_valid = 1'b1; pc_i = 32'h8000_0800;
    tick();
    next_pc_valid = 1'b0;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("mid_reset");
    tick();
    check_all_zero("after_reset");
    run_fetch(32'hbfc0_0000, 0, 0, 2'b00, 32'h2408_0001, 32'h2408_0001, 32'h0);

    tick();
    chk("valid_single_cycle", {31'b0, valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
